// File: rtl/intmul_tiled_if.sv
// Operand/result bundle for the tiled multiplier: request side (A, B, qH_in)
// and aligned result side (C, qH_out) with their valid flags.
interface intmul_tiled_if #(
  parameter int LOGQ  = 60,
  parameter int LOGQH = 17
);
  logic                in_valid;
  logic [LOGQ-1:0]     A;
  logic [LOGQ-1:0]     B;
  logic [LOGQH-1:0]    qH_in;
  logic                out_valid;
  logic [2*LOGQ-1:0]   C;
  logic [LOGQH-1:0]    qH_out;

  modport master (
    output in_valid, A, B, qH_in,
    input  out_valid, C, qH_out
  );

  modport slave (
    input  in_valid, A, B, qH_in,
    output out_valid, C, qH_out
  );
endinterface

// File: rtl/intmul_tiled.sv
// Pipelined LOGQ x LOGQ unsigned multiplier: DSP-sized tile partial products
// summed by a registered pairwise adder tree, with qH/valid carried alongside.
module intmul_tiled #(
  parameter int LOGQ   = 60,
  parameter int LOGQH  = 17,
  parameter int TA     = 24,
  parameter int TB     = 17,
  parameter int FF_IN  = 1,
  parameter int FF_OUT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  intmul_tiled_if.slave bus
);

  localparam int K   = 2 * LOGQ;
  localparam int NA  = (LOGQ + TA - 1) / TA;
  localparam int NB  = (LOGQ + TB - 1) / TB;
  localparam int NPP = NA * NB;
  localparam int D   = (NPP > 1) ? $clog2(NPP) : 0;
  localparam int LAT = FF_IN + 1 + D + FF_OUT;
  localparam int WA  = NA * TA;
  localparam int WB  = NB * TB;
  localparam int TW  = TA + TB;
  // Padded-operand product width: every tree node fits without losing a carry.
  localparam int W   = WA + WB;

  function automatic int level_count(input int lvl);
    return (NPP + (1 << lvl) - 1) >> lvl;
  endfunction

  logic [LOGQ-1:0] a_s;
  logic [LOGQ-1:0] b_s;
  logic [WA-1:0]   a_pad;
  logic [WB-1:0]   b_pad;
  logic [W-1:0]    node [D+1][NPP];

  generate
    if (FF_IN != 0) begin : g_in
      logic [LOGQ-1:0] a_reg;
      logic [LOGQ-1:0] b_reg;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          a_reg <= '0;
          b_reg <= '0;
        end else if (ce) begin
          a_reg <= bus.A;
          b_reg <= bus.B;
        end
      end
      assign a_s = a_reg;
      assign b_s = b_reg;
    end else begin : g_no_in
      assign a_s = bus.A;
      assign b_s = bus.B;
    end
  endgenerate

  assign a_pad = WA'(a_s);
  assign b_pad = WB'(b_s);

  // Level 0 of the tree: registered tile products placed at their weight.
  generate
    for (genvar gi = 0; gi < NA; gi++) begin : g_pa
      for (genvar gj = 0; gj < NB; gj++) begin : g_pb
        logic [TW-1:0] pp_reg;
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            pp_reg <= '0;
          end else if (ce) begin
            pp_reg <= TW'(a_pad[gi*TA +: TA]) * TW'(b_pad[gj*TB +: TB]);
          end
        end
        assign node[0][gi*NB + gj] = W'(pp_reg) << (gi*TA + gj*TB);
      end
    end
  endgenerate

  // Each level pairs neighbours; an odd leftover is re-registered unchanged.
  generate
    for (genvar gl = 0; gl < D; gl++) begin : g_lvl
      localparam int N_IN  = level_count(gl);
      localparam int N_OUT = level_count(gl + 1);
      for (genvar gi = 0; gi < NPP; gi++) begin : g_slot
        if (gi < N_OUT) begin : g_node
          logic [W-1:0] node_reg;
          if (2*gi + 1 < N_IN) begin : g_add
            always_ff @(posedge clk or negedge rst) begin
              if (!rst) begin
                node_reg <= '0;
              end else if (ce) begin
                node_reg <= node[gl][2*gi] + node[gl][2*gi + 1];
              end
            end
          end else begin : g_pass
            always_ff @(posedge clk or negedge rst) begin
              if (!rst) begin
                node_reg <= '0;
              end else if (ce) begin
                node_reg <= node[gl][2*gi];
              end
            end
          end
          assign node[gl+1][gi] = node_reg;
        end else begin : g_zero
          assign node[gl+1][gi] = '0;
        end
      end
    end
  endgenerate

  generate
    if (FF_OUT != 0) begin : g_out
      logic [K-1:0] c_reg;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          c_reg <= '0;
        end else if (ce) begin
          c_reg <= K'(node[D][0]);
        end
      end
      assign bus.C = c_reg;
    end else begin : g_no_out
      assign bus.C = K'(node[D][0]);
    end
  endgenerate

  logic             valid_reg [LAT];
  logic [LOGQH-1:0] qh_reg    [LAT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LAT; i++) begin
        valid_reg[i] <= 1'b0;
        qh_reg[i]    <= '0;
      end
    end else if (ce) begin
      valid_reg[0] <= bus.in_valid;
      qh_reg[0]    <= bus.qH_in;
      for (int i = 1; i < LAT; i++) begin
        valid_reg[i] <= valid_reg[i-1];
        qh_reg[i]    <= qh_reg[i-1];
      end
    end
  end

  assign bus.out_valid = valid_reg[LAT-1];
  assign bus.qH_out    = qh_reg[LAT-1];

endmodule

// File: tb/tb_intmul_tiled.sv
// Directed checks of the tiled multiplier: default build plus LOGQ=64 and
// LOGQ=17 builds for latency and padded-tile coverage.
module tb_intmul_tiled;

  localparam int LAT   = 7;
  localparam int LAT64 = 7;
  localparam int LAT17 = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ce  = 1'b0;
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  intmul_tiled_if #(.LOGQ(60), .LOGQH(17)) bus   ();
  intmul_tiled_if #(.LOGQ(64), .LOGQH(17)) bus64 ();
  intmul_tiled_if #(.LOGQ(17), .LOGQH(17)) bus17 ();

  intmul_tiled #(.LOGQ(60)) dut   (.clk(clk), .rst(rst), .ce(ce), .bus(bus));
  intmul_tiled #(.LOGQ(64)) dut64 (.clk(clk), .rst(rst), .ce(ce), .bus(bus64));
  intmul_tiled #(.LOGQ(17)) dut17 (.clk(clk), .rst(rst), .ce(ce), .bus(bus17));

  task automatic test_reset();
    rst = 1'b0;
    ce  = 1'b1;
    bus.in_valid = 1'b1;   bus.A = '1;   bus.B = '1;   bus.qH_in = '1;
    bus64.in_valid = 1'b1; bus64.A = '1; bus64.B = '1; bus64.qH_in = '1;
    bus17.in_valid = 1'b1; bus17.A = '1; bus17.B = '1; bus17.qH_in = '1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.C !== '0 || bus.qH_out !== '0) begin
      failures++;
      $display("FAIL reset_hold valid=%b C=%h qH=%h expected all zero", bus.out_valid, bus.C, bus.qH_out);
    end
    checks++;
    if (bus64.out_valid !== 1'b0 || bus64.C !== '0 || bus17.out_valid !== 1'b0 || bus17.C !== '0) begin
      failures++;
      $display("FAIL reset_hold_sweep v64=%b C64=%h v17=%b C17=%h expected all zero",
               bus64.out_valid, bus64.C, bus17.out_valid, bus17.C);
    end
    bus.in_valid = 1'b0;   bus.A = '0;   bus.B = '0;   bus.qH_in = '0;
    bus64.in_valid = 1'b0; bus64.A = '0; bus64.B = '0; bus64.qH_in = '0;
    bus17.in_valid = 1'b0; bus17.A = '0; bus17.B = '0; bus17.qH_in = '0;
    rst = 1'b1;
    repeat (LAT + 1) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.C !== '0 || bus.qH_out !== '0) begin
      failures++;
      $display("FAIL reset_release valid=%b C=%h qH=%h expected all zero", bus.out_valid, bus.C, bus.qH_out);
    end
    $display("reset: done");
  endtask

  task automatic test_max_operands();
    logic [119:0] exp_c;
    exp_c = 120'hFFFF_FFFF_FFFF_FFE0_0000_0000_0000_01;
    @(negedge clk);
    bus.A = 60'hFFF_FFFF_FFFF_FFFF; bus.B = 60'hFFF_FFFF_FFFF_FFFF;
    bus.qH_in = 17'h1ABCD; bus.in_valid = 1'b1;
    $display("max: A=%h B=%h qH=%h", bus.A, bus.B, bus.qH_in);
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.qH_in = '0;
      end
      if (k == LAT) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.C !== exp_c || bus.qH_out !== 17'h1ABCD) begin
          failures++;
          $display("FAIL max_result valid=%b C=%h qH=%h expected valid=1 C=%h qH=1abcd",
                   bus.out_valid, bus.C, bus.qH_out, exp_c);
        end
      end else begin
        checks++;
        if (bus.out_valid !== 1'b0) begin
          failures++;
          $display("FAIL max_valid_edge%0d valid=%b expected 0", k, bus.out_valid);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 16;
    logic [59:0]  sa [N];
    logic [59:0]  sb [N];
    logic [16:0]  sq [N];
    logic [119:0] se [N];
    logic [63:0]  r;
    int idx;
    sa[0] = 60'd0;                   sb[0] = 60'hFFF_FFFF_FFFF_FFFF; se[0] = 120'd0;
    sa[1] = 60'd1;                   sb[1] = 60'hFFF_FFFF_FFFF_FFFF; se[1] = 120'hFFF_FFFF_FFFF_FFFF;
    sa[2] = 60'h800_0000_0000_0000;  sb[2] = 60'h800_0000_0000_0000; se[2] = 120'd1 << 118;
    sa[3] = 60'd3;                   sb[3] = 60'd5;                  se[3] = 120'd15;
    sa[4] = 60'd12345;               sb[4] = 60'd1000;               se[4] = 120'd12345000;
    sa[5] = 60'h1_0000_0000;         sb[5] = 60'h1_0000_0000;        se[5] = 120'd1 << 64;
    sa[6] = 60'hFFF_FFFF_FFFF_FFFF;  sb[6] = 60'd1;                  se[6] = 120'hFFF_FFFF_FFFF_FFFF;
    sa[7] = 60'hFFFF_FFFF;           sb[7] = 60'hFFFF_FFFF;          se[7] = 120'hFFFF_FFFE_0000_0001;
    for (int i = 8; i < N; i++) begin
      r = {$urandom(), $urandom()}; sa[i] = r[59:0];
      r = {$urandom(), $urandom()}; sb[i] = r[59:0];
      se[i] = {60'd0, sa[i]} * {60'd0, sb[i]};
    end
    for (int i = 0; i < N; i++) sq[i] = 17'(i * 4099 + 7);
    for (int c = 0; c <= N + LAT; c++) begin
      @(negedge clk);
      idx = c - LAT;
      checks++;
      if (idx >= 0 && idx < N) begin
        if (bus.out_valid !== 1'b1 || bus.C !== se[idx] || bus.qH_out !== sq[idx]) begin
          failures++;
          $display("FAIL b2b_%0d valid=%b C=%h qH=%h expected valid=1 C=%h qH=%h",
                   idx, bus.out_valid, bus.C, bus.qH_out, se[idx], sq[idx]);
        end
      end else if (bus.out_valid !== 1'b0) begin
        failures++;
        $display("FAIL b2b_idle_c%0d valid=%b expected 0", c, bus.out_valid);
      end
      if (c < N) begin
        bus.in_valid = 1'b1; bus.A = sa[c]; bus.B = sb[c]; bus.qH_in = sq[c];
        $display("b2b op %0d: A=%h B=%h qH=%h", c, sa[c], sb[c], sq[c]);
      end else begin
        bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.qH_in = '0;
      end
    end
  endtask

  task automatic test_stall();
    logic [59:0]  sa [3];
    logic [59:0]  sb [3];
    logic [119:0] se [3];
    int en;
    int idx;
    sa[0] = 60'd3;                  sb[0] = 60'd5;                  se[0] = 120'd15;
    sa[1] = 60'h800_0000_0000_0000; sb[1] = 60'd2;                  se[1] = 120'd1 << 60;
    sa[2] = 60'd0;                  sb[2] = 60'hFFF_FFFF_FFFF_FFFF; se[2] = 120'd0;
    en = 0;
    ce = 1'b1;
    for (int c = 0; c <= 16; c++) begin
      @(negedge clk);
      if (c > 0 && ce) en++;
      idx = en - LAT;
      checks++;
      if (idx >= 0 && idx < 3) begin
        if (bus.out_valid !== 1'b1 || bus.C !== se[idx] || bus.qH_out !== 17'(idx + 1)) begin
          failures++;
          $display("FAIL stall_c%0d valid=%b C=%h qH=%h expected valid=1 C=%h qH=%h",
                   c, bus.out_valid, bus.C, bus.qH_out, se[idx], 17'(idx + 1));
        end
      end else if (bus.out_valid !== 1'b0) begin
        failures++;
        $display("FAIL stall_idle_c%0d valid=%b expected 0", c, bus.out_valid);
      end
      ce = !(c >= 7 && c <= 10);
      if (c < 3) begin
        bus.in_valid = 1'b1; bus.A = sa[c]; bus.B = sb[c]; bus.qH_in = 17'(c + 1);
        $display("stall op %0d: A=%h B=%h", c, sa[c], sb[c]);
      end else if (c == 8) begin
        bus.in_valid = 1'b1; bus.A = 60'd99; bus.B = 60'd99; bus.qH_in = 17'h55;
        $display("stall op dropped: A=63 B=63 with ce=0");
      end else begin
        bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.qH_in = '0;
      end
    end
    ce = 1'b1;
  endtask

  task automatic test_reset_midflight();
    int idx;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      idx = c - LAT;
      if (idx >= 0) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.C !== 120'((idx + 2) * (idx + 10))) begin
          failures++;
          $display("FAIL midflight_pre_%0d valid=%b C=%h expected valid=1 C=%h",
                   idx, bus.out_valid, bus.C, 120'((idx + 2) * (idx + 10)));
        end
      end
      if (c < 5) begin
        bus.in_valid = 1'b1; bus.A = 60'(c + 2); bus.B = 60'(c + 10); bus.qH_in = 17'(c + 100);
        $display("midflight op %0d: A=%0d B=%0d", c, c + 2, c + 10);
      end else begin
        bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.qH_in = '0;
      end
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.C !== '0 || bus.qH_out !== '0) begin
      failures++;
      $display("FAIL midflight_async_clear valid=%b C=%h qH=%h expected all zero",
               bus.out_valid, bus.C, bus.qH_out);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
        failures++;
        $display("FAIL midflight_ghost_c%0d valid=%b C=%h expected valid=0", c, bus.out_valid, bus.C);
      end
    end
    bus.in_valid = 1'b1; bus.A = 60'd7; bus.B = 60'd9; bus.qH_in = 17'h0777;
    $display("midflight new op: A=7 B=9");
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.qH_in = '0;
      end
      checks++;
      if (k == LAT) begin
        if (bus.out_valid !== 1'b1 || bus.C !== 120'd63 || bus.qH_out !== 17'h0777) begin
          failures++;
          $display("FAIL midflight_new valid=%b C=%h qH=%h expected valid=1 C=3f qH=777",
                   bus.out_valid, bus.C, bus.qH_out);
        end
      end else if (bus.out_valid !== 1'b0) begin
        failures++;
        $display("FAIL midflight_new_early_k%0d valid=%b expected 0", k, bus.out_valid);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_width_sweep();
    localparam int N = 3;
    logic [63:0]  a64 [N];
    logic [63:0]  b64 [N];
    logic [127:0] e64 [N];
    logic [16:0]  a17 [N];
    logic [16:0]  b17 [N];
    logic [33:0]  e17 [N];
    logic [31:0]  r;
    int i64;
    int i17;
    a64[0] = 64'hFFFF_FFFF_FFFF_FFFF; b64[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    e64[0] = 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001;
    a64[1] = {$urandom(), $urandom()}; b64[1] = {$urandom(), $urandom()};
    e64[1] = {64'd0, a64[1]} * {64'd0, b64[1]};
    a64[2] = 64'h8000_0000_0000_0000; b64[2] = 64'h8000_0000_0000_0000;
    e64[2] = 128'd1 << 126;
    a17[0] = 17'h1FFFF; b17[0] = 17'h1FFFF; e17[0] = 34'h3_FFFC_0001;
    r = $urandom(); a17[1] = r[16:0];
    r = $urandom(); b17[1] = r[16:0];
    e17[1] = {17'd0, a17[1]} * {17'd0, b17[1]};
    a17[2] = 17'h10000; b17[2] = 17'd3; e17[2] = 34'h3_0000;
    for (int c = 0; c <= N + LAT64; c++) begin
      @(negedge clk);
      i64 = c - LAT64;
      i17 = c - LAT17;
      checks++;
      if (i64 >= 0 && i64 < N) begin
        if (bus64.out_valid !== 1'b1 || bus64.C !== e64[i64] || bus64.qH_out !== 17'(i64 + 40)) begin
          failures++;
          $display("FAIL w64_%0d valid=%b C=%h qH=%h expected valid=1 C=%h qH=%h",
                   i64, bus64.out_valid, bus64.C, bus64.qH_out, e64[i64], 17'(i64 + 40));
        end
      end else if (bus64.out_valid !== 1'b0) begin
        failures++;
        $display("FAIL w64_idle_c%0d valid=%b expected 0", c, bus64.out_valid);
      end
      checks++;
      if (i17 >= 0 && i17 < N) begin
        if (bus17.out_valid !== 1'b1 || bus17.C !== e17[i17] || bus17.qH_out !== 17'(i17 + 70)) begin
          failures++;
          $display("FAIL w17_%0d valid=%b C=%h qH=%h expected valid=1 C=%h qH=%h",
                   i17, bus17.out_valid, bus17.C, bus17.qH_out, e17[i17], 17'(i17 + 70));
        end
      end else if (bus17.out_valid !== 1'b0) begin
        failures++;
        $display("FAIL w17_idle_c%0d valid=%b expected 0", c, bus17.out_valid);
      end
      if (c < N) begin
        bus64.in_valid = 1'b1; bus64.A = a64[c]; bus64.B = b64[c]; bus64.qH_in = 17'(c + 40);
        bus17.in_valid = 1'b1; bus17.A = a17[c]; bus17.B = b17[c]; bus17.qH_in = 17'(c + 70);
        $display("sweep op %0d: A64=%h B64=%h A17=%h B17=%h", c, a64[c], b64[c], a17[c], b17[c]);
      end else begin
        bus64.in_valid = 1'b0; bus64.A = '0; bus64.B = '0; bus64.qH_in = '0;
        bus17.in_valid = 1'b0; bus17.A = '0; bus17.B = '0; bus17.qH_in = '0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_max_operands();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    test_width_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/intmul_tiled.md
Name: intmul_tiled

Overview:
- Pipelined LOGQ x LOGQ unsigned integer multiplier built from DSP-sized tile partial products and a registered adder tree.
- Sits directly upstream of the word-level Montgomery reduction stage. Produces the 2*LOGQ-bit product C that the reduction consumes.
- Carries the modulus high word qH, plus a valid flag, through a delay line matched to its latency so qH arrives aligned with C.
- Supports a clock-enable stall so it can sit in a back-pressured datapath.

Parameters:
- LOGQ, 60, operand width in bits; product width K = 2*LOGQ.
- LOGQH, 17, width of the qH sideband.
- TA, 24, A-operand tile width (DSP port A).
- TB, 17, B-operand tile width (DSP port B).
- FF_IN, 1, input register stage present (0/1).
- FF_OUT, 1, output register stage present (0/1).
- Derived, not overridable:
  - NA = ceil(LOGQ/TA), NB = ceil(LOGQ/TB), NPP = NA*NB.
  - D = ceil(log2(NPP)), or 0 if NPP = 1.
  - LAT = FF_IN + 1 + D + FF_OUT (default: NA=3, NB=4, NPP=12, D=4, LAT=7).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- ce  in  1  clock enable; when 0, every pipeline register holds its value.
- in_valid  in  1  A/B/qH_in carry a valid operation this cycle.
- A  in  LOGQ  multiplicand.
- B  in  LOGQ  multiplier.
- qH_in  in  LOGQH  modulus high word accompanying this operation.
- out_valid  out  1  C/qH_out are valid.
- C  out  2*LOGQ  product A*B, exact, no truncation.
- qH_out  out  LOGQH  qH_in delayed by LAT enabled cycles.

Behaviour:
- Reset (rst=0, asynchronous):
  - All pipeline registers clear to 0 immediately, including the valid pipe, qH delay line and datapath stages.
  - out_valid=0, C=0, qH_out=0 while rst=0 and until the first valid result emerges after release.
  - In-flight operations at reset assertion are discarded; none appear after release.
- Throughput and latency:
  - Fully pipelined: one operation per enabled cycle, no internal state machine.
  - Operation sampled on an enabled edge at cycle t appears on C/out_valid after exactly LAT enabled edges.
  - With FF_IN=0 and FF_OUT=0 the operands feed the partial-product stage combinationally; minimum LAT = 1 + D.
- Tiling:
  - A is split into NA slices of TA bits, B into NB slices of TB bits, LSB first.
  - The top slice of each operand is zero-padded when LOGQ is not a multiple of the tile width.
  - Partial product P[i][j] = A_i*B_j has width TA+TB. It is registered in the partial-product stage, then shifted left by i*TA + j*TB.
- Adder tree:
  - D registered levels, each summing pairs; an odd leftover passes through that level registered.
  - Intermediate widths are sized so no carry is lost.
  - The final sum is truncated to 2*LOGQ bits. This is exact, since A*B < 2^(2*LOGQ).
- Valid/sideband:
  - in_valid and qH_in shift through LAT-deep registers advanced only when ce=1.
  - When ce=0, out_valid, C and qH_out are held, not cleared.
  - The datapath advances regardless of in_valid. C when out_valid=0 is don't-care for the consumer but must be deterministic (0 after reset).
- Simultaneous events:
  - rst=0 overrides ce and in_valid.
  - ce=0 with in_valid=1 drops that input. Upstream must hold in_valid/operands until ce=1.
- No overflow, full or empty conditions exist. The block never back-pressures; flow control is external via ce.

Test Plan:
- Max operands: A=B=2^60-1, qH_in=0x1ABCD, one cycle of in_valid, ce=1 → exactly 7 cycles later out_valid=1 for one cycle, C=2^120-2^61+1, qH_out=0x1ABCD.
- Streaming: 1000 back-to-back random (A,B,qH) with ce=1 → outputs in order, one per cycle, each C=A*B and matching qH, first at cycle 7.
- Stall: issue 3 ops (A=3,B=5; A=2^59,B=2; A=0,B=2^60-1), hold ce=0 for 4 cycles mid-flight → outputs 15, 2^60, 0 appear after 7 enabled edges each; outputs frozen during stall; no duplicates or drops.
- Reset mid-flight: 5 valid ops in flight, pulse rst=0 asynchronously between edges → out_valid, C and qH_out go to 0 immediately; after release none of the 5 ops appear; a new op A=7,B=9 yields C=63 after 7 cycles.
- Width sweep: LOGQ=64 (NA=3, NB=4, padded tiles), LOGQ=17 with TA=24, TB=17 (NPP=1, D=0, LAT=3) → random A*B exact and LAT matches formula in each configuration.
- Corner operands: A=0,B=max → 0; A=1,B=max → max; A=2^(LOGQ-1), B=2^(LOGQ-1) → 2^(2*LOGQ-2).
